// File: rtl/sd_bus_arb_if.sv
// Signal bundle between sd_bus_arb and the init/read/write engines plus the SD pads.
// The arbiter uses the slave modport; the engine side (or a bench) uses master.
interface sd_bus_arb_if;
  logic init_done;
  logic init_mosi;
  logic init_csn;
  logic wr_req;
  logic rd_req;
  logic wr_ok;
  logic rd_ok;
  logic wr_mosi;
  logic wr_csn;
  logic rd_mosi;
  logic rd_csn;
  logic SD_MOSI;
  logic SD_CSn;
  logic wr_seq;
  logic rd_seq;
  logic wr_gnt;
  logic rd_gnt;
  logic wr_rst_n;
  logic rd_rst_n;
  logic busy;
  logic err;

  modport slave (
    input  init_done, init_mosi, init_csn,
    input  wr_req, rd_req, wr_ok, rd_ok,
    input  wr_mosi, wr_csn, rd_mosi, rd_csn,
    output SD_MOSI, SD_CSn, wr_seq, rd_seq, wr_gnt, rd_gnt,
    output wr_rst_n, rd_rst_n, busy, err
  );

  modport master (
    output init_done, init_mosi, init_csn,
    output wr_req, rd_req, wr_ok, rd_ok,
    output wr_mosi, wr_csn, rd_mosi, rd_csn,
    input  SD_MOSI, SD_CSn, wr_seq, rd_seq, wr_gnt, rd_gnt,
    input  wr_rst_n, rd_rst_n, busy, err
  );
endinterface

// File: rtl/sd_bus_arb.sv
// SD SPI bus sequencer/arbiter: init engine owns the bus until init_done, then read/write
// engines are granted one transaction at a time. Optional watchdog: define SD_ARB_TIMEOUT_EN.
module sd_bus_arb #(
  parameter int GAP_CLKS  = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic         SD_CK,
  input  logic         rst_n,
  sd_bus_arb_if.slave  bus
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  if (GAP_CLKS < 2 || GAP_CLKS > 255 || TIMEOUT_W < 2) begin : g_bad_param
    $error("sd_bus_arb: GAP_CLKS must be 2..255 and TIMEOUT_W at least 2");
  end

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic       r_wr_gnt;
  logic       r_rd_gnt;
  logic       r_wr_seq;
  logic       r_rd_seq;
  logic       r_wr_rst_n;
  logic       r_rd_rst_n;
  logic       r_rst_hold;
  logic       r_busy;
  logic       r_last_rd;
  logic [7:0] r_gap_cnt;
  logic       w_any_req;
  logic       w_wr_win;
  logic       w_ok;
  logic       w_timeout;
  logic       w_done;
  logic       w_mosi;
  logic       w_csn;

  assign w_any_req = bus.wr_req | bus.rd_req;
  // On a tie the engine that was not served last wins.
  assign w_wr_win  = bus.wr_req & (~bus.rd_req | r_last_rd);
  assign w_ok      = r_wr_gnt ? bus.wr_ok : bus.rd_ok;
  assign w_done    = w_ok | w_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:   if (bus.init_done) w_state_next = ST_IDLE;
      ST_IDLE:   if (w_any_req) w_state_next = ST_START;
      ST_START:  w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_done) w_state_next = ST_GAP;
      ST_GAP:    if (r_gap_cnt == 8'd0) w_state_next = ST_IDLE;
      default:   w_state_next = ST_INIT;
    endcase
  end

  always_ff @(negedge SD_CK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_wr_gnt   <= 1'b0;
      r_rd_gnt   <= 1'b0;
      r_wr_seq   <= 1'b0;
      r_rd_seq   <= 1'b0;
      r_wr_rst_n <= 1'b1;
      r_rd_rst_n <= 1'b1;
      r_rst_hold <= 1'b0;
      r_busy     <= 1'b1;
      r_last_rd  <= 1'b1;
      r_gap_cnt  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);

      // Soft reset is held for the exit edge plus one more, then released.
      if (r_rst_hold) begin
        r_rst_hold <= 1'b0;
      end else begin
        r_wr_rst_n <= 1'b1;
        r_rd_rst_n <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_wr_gnt  <= w_wr_win;
            r_rd_gnt  <= ~w_wr_win;
            r_wr_seq  <= w_wr_win;
            r_rd_seq  <= ~w_wr_win;
            r_last_rd <= ~w_wr_win;
          end
        end
        ST_START: begin
          r_wr_seq <= 1'b0;
          r_rd_seq <= 1'b0;
        end
        ST_ACTIVE: begin
          if (w_done) begin
            r_wr_gnt   <= 1'b0;
            r_rd_gnt   <= 1'b0;
            r_wr_rst_n <= ~r_wr_gnt;
            r_rd_rst_n <= ~r_rd_gnt;
            r_rst_hold <= 1'b1;
            r_gap_cnt  <= 8'(GAP_CLKS - 1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != 8'd0) r_gap_cnt <= r_gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wdog;
  logic [TIMEOUT_W-1:0] w_wdog_inc;
  logic                 r_err;

  assign w_wdog_inc = r_wdog + 1'b1;
  // Fires on the ACTIVE edge that brings the count to all-ones.
  assign w_timeout  = (r_state == ST_ACTIVE) && (&w_wdog_inc);

  always_ff @(negedge SD_CK or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_START) r_wdog <= '0;
      else if (r_state == ST_ACTIVE) r_wdog <= w_wdog_inc;
      if (w_timeout && !w_ok) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_comb begin
    w_mosi = 1'b1;
    w_csn  = 1'b1;
    case (r_state)
      ST_INIT: begin
        w_mosi = bus.init_mosi;
        w_csn  = bus.init_csn;
      end
      ST_START, ST_ACTIVE: begin
        w_mosi = r_wr_gnt ? bus.wr_mosi : bus.rd_mosi;
        w_csn  = r_wr_gnt ? bus.wr_csn  : bus.rd_csn;
      end
      default: ;
    endcase
  end

  assign bus.SD_MOSI  = w_mosi;
  assign bus.SD_CSn   = w_csn;
  assign bus.wr_gnt   = r_wr_gnt;
  assign bus.rd_gnt   = r_rd_gnt;
  assign bus.wr_seq   = r_wr_seq;
  assign bus.rd_seq   = r_rd_seq;
  assign bus.wr_rst_n = r_wr_rst_n;
  assign bus.rd_rst_n = r_rd_rst_n;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_sd_bus_arb.sv
// Directed + randomized bench for sd_bus_arb; a transaction-level model predicts the
// winner of each arbitration, grant length, gap timing, soft-reset pulse and err.
module tb_sd_bus_arb;
  localparam int GAP = 8;
  localparam int TW  = 4;

  logic SD_CK = 1'b0;
  logic rst_n;
  sd_bus_arb_if bus ();

  sd_bus_arb #(.GAP_CLKS(GAP), .TIMEOUT_W(TW)) dut (
    .SD_CK (SD_CK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 SD_CK = ~SD_CK;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  bit pend_wr = 1'b0;
  bit pend_rd = 1'b0;
  bit last_rd = 1'b1;
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge SD_CK);
  endtask

  task automatic drive_bus();
    bus.wr_mosi = 1'($urandom);
    bus.wr_csn  = 1'($urandom);
    bus.rd_mosi = 1'($urandom);
    bus.rd_csn  = 1'($urandom);
  endtask

  // Samples with grant high: the START cycle plus one per ACTIVE cycle.
  function automatic int exp_hi(input int len);
`ifdef SD_ARB_TIMEOUT_EN
    if (len < 0 || len >= (1 << TW)) return (1 << TW);
`endif
    return len + 1;
  endfunction

  // Called at a sample point with the DUT idle. len: cycles from seq to ok (-1 = never).
  task automatic do_txn(input bit add_wr, input bit add_rd, input int len, input bit noise);
    bit w;
    int hi;
    int seqhi;
    int bound;
    hi = 0;
    seqhi = 0;
    pend_wr = pend_wr | add_wr;
    pend_rd = pend_rd | add_rd;
    w = pend_wr && (!pend_rd || last_rd);
    last_rd = !w;
    bus.wr_req = pend_wr;
    bus.rd_req = pend_rd;
    tick();
    chk("grant_wr", bus.wr_gnt, w);
    chk("grant_rd", bus.rd_gnt, !w);
    if (w) begin
      pend_wr = 1'b0;
      bus.wr_req = 1'b0;
    end else begin
      pend_rd = 1'b0;
      bus.rd_req = 1'b0;
    end
    bound = ((len < 0) ? (1 << TW) : len) + 20;
    for (int i = 0; i < bound; i++) begin
      if (!(w ? bus.wr_gnt : bus.rd_gnt)) break;
      hi++;
      if (w ? bus.wr_seq : bus.rd_seq) seqhi++;
      chk("bus_csn", bus.SD_CSn, w ? bus.wr_csn : bus.rd_csn);
      chk("bus_mosi", bus.SD_MOSI, w ? bus.wr_mosi : bus.rd_mosi);
      if (i == len) begin
        if (w) bus.wr_ok = 1'b1;
        else   bus.rd_ok = 1'b1;
      end
      if (noise) begin
        if (w) bus.rd_ok = 1'($urandom);
        else   bus.wr_ok = 1'($urandom);
      end
      drive_bus();
      tick();
    end
    chk("gnt_cycles", hi, exp_hi(len));
    chk("seq_cycles", seqhi, 1);
    if (exp_hi(len) != len + 1) err_exp = 1'b1;
    for (int k = 1; k <= GAP; k++) begin
      chk("gap_wr_gnt", bus.wr_gnt, 0);
      chk("gap_rd_gnt", bus.rd_gnt, 0);
      chk("gap_csn", bus.SD_CSn, 1);
      chk("gap_mosi", bus.SD_MOSI, 1);
      chk("gap_busy", bus.busy, 1);
      chk("gap_wr_rst_n", bus.wr_rst_n, (w && k <= 2) ? 0 : 1);
      chk("gap_rd_rst_n", bus.rd_rst_n, (!w && k <= 2) ? 0 : 1);
      if (k == 1) begin
        bus.wr_ok = 1'b0;
        bus.rd_ok = 1'b0;
      end
      drive_bus();
      tick();
    end
    chk("idle_busy", bus.busy, 0);
    chk("err", bus.err, err_exp);
    txn_no++;
    $display("txn %0d: %s len=%0d gnt_cycles=%0d err=%0b", txn_no, w ? "write" : "read",
             len, hi, bus.err);
  endtask

  initial begin
    bit aw;
    bit ar;
    rst_n = 1'b0;
    bus.init_done = 1'b0;
    bus.init_mosi = 1'b1;
    bus.init_csn  = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_ok  = 1'b0;
    bus.rd_ok  = 1'b0;
    drive_bus();
    repeat (2) tick();
    chk("rst_wr_gnt", bus.wr_gnt, 0);
    chk("rst_rd_gnt", bus.rd_gnt, 0);
    chk("rst_wr_seq", bus.wr_seq, 0);
    chk("rst_rd_seq", bus.rd_seq, 0);
    chk("rst_wr_rst_n", bus.wr_rst_n, 1);
    chk("rst_rd_rst_n", bus.rd_rst_n, 1);
    chk("rst_busy", bus.busy, 1);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      bus.init_csn  = (i % 2 == 0) ? 1'b0 : 1'b1;
      bus.init_mosi = 1'($urandom);
      #1;
      chk("init_csn", bus.SD_CSn, bus.init_csn);
      chk("init_mosi", bus.SD_MOSI, bus.init_mosi);
      chk("init_busy", bus.busy, 1);
      chk("init_gnt", {bus.wr_gnt, bus.rd_gnt}, 0);
      tick();
    end
    bus.init_csn  = 1'b0;
    bus.init_mosi = 1'b0;
    bus.init_done = 1'b1;
    tick();
    chk("init_to_idle_busy", bus.busy, 0);
    chk("idle_csn", bus.SD_CSn, 1);
    chk("idle_mosi", bus.SD_MOSI, 1);
    bus.init_done = 1'b0;

    do_txn(1'b1, 1'b0, 600, 1'b0);
    for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, int'($urandom_range(1, 12)), 1'b0);
    do_txn(1'b0, 1'b0, 1, 1'b0);
    do_txn(1'b1, 1'b0, 20, 1'b1);

    for (int i = 0; i < 25; i++) begin
      aw = 1'($urandom);
      ar = 1'($urandom);
      if (!pend_wr && !pend_rd && !aw && !ar) aw = 1'b1;
      do_txn(aw, ar, int'($urandom_range(1, 30)), 1'($urandom));
    end
    while (pend_wr || pend_rd) do_txn(1'b0, 1'b0, int'($urandom_range(1, 5)), 1'b0);

`ifdef SD_ARB_TIMEOUT_EN
    do_txn(1'b1, 1'b0, -1, 1'b0);
    do_txn(1'b0, 1'b1, 5, 1'b0);
`endif

    // Asynchronous reset in the middle of a read.
    pend_rd = 1'b1;
    last_rd = 1'b1;
    bus.rd_req = 1'b1;
    tick();
    chk("mid_rd_gnt", bus.rd_gnt, 1);
    bus.rd_req = 1'b0;
    pend_rd = 1'b0;
    repeat (3) tick();
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_gnt", bus.wr_gnt, 0);
    chk("arst_rd_gnt", bus.rd_gnt, 0);
    chk("arst_seq", {bus.wr_seq, bus.rd_seq}, 0);
    chk("arst_rst_n", {bus.wr_rst_n, bus.rd_rst_n}, 2'b11);
    chk("arst_busy", bus.busy, 1);
    chk("arst_err", bus.err, 0);
    bus.init_csn = ~bus.rd_csn;
    #1;
    chk("arst_bus_init", bus.SD_CSn, bus.init_csn);
    last_rd = 1'b1;
    err_exp = 1'b0;
    bus.init_done = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("reinit_busy", bus.busy, 0);
    do_txn(1'b1, 1'b1, 3, 1'b0);
    do_txn(1'b0, 1'b0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_bus_arb.md
# sd_bus_arb

Sequencer and arbiter for the shared SD SPI bus. It hands SD_MOSI/SD_CSn to the init engine until card initialisation completes. It then grants the bus to the read or write engine one transaction at a time, and strobes the granted engine's start input. After each transaction it re-arms the engine through a per-engine soft reset. It sits between the init/read/write engines and the SD pads at the top level.

## Interface
Parameters:
- GAP_CLKS, 8, idle SD_CK cycles (CSn high, MOSI high) between transactions; legal range 2..255
- TIMEOUT_W, 16, watchdog counter width; used only with SD_ARB_TIMEOUT_EN

Ports:
- SD_CK  in  1  SPI clock; all state updates on negedge SD_CK
- rst_n  in  1  reset, asynchronous, active-low
- init_done  in  1  level from init engine, sticky high once the card is ready
- init_mosi, init_csn  in  1 each  init engine bus drive
- wr_req, rd_req  in  1 each  level requests; held until the matching grant
- wr_ok, rd_ok  in  1 each  engine completion level; cleared only by engine reset
- wr_mosi, wr_csn, rd_mosi, rd_csn  in  1 each  engine bus drive
- SD_MOSI, SD_CSn  out  1 each  pad drive
- wr_seq, rd_seq  out  1 each  one-cycle start strobe to the engine
- wr_gnt, rd_gnt  out  1 each  grant level
- wr_rst_n, rd_rst_n  out  1 each  engine soft reset, active-low; ANDed with rst_n at top
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag

## Operation
- The states are INIT, IDLE, START, ACTIVE and GAP. All state and outputs are registered, except the bus mux.
- Bus mux (combinational from the registered state/grant):
  - INIT: SD_MOSI/SD_CSn = init_mosi/init_csn.
  - START/ACTIVE: SD_MOSI/SD_CSn come from the granted engine.
  - IDLE/GAP: SD_MOSI=1, SD_CSn=1.
- INIT → IDLE when init_done=1. init_done dropping after INIT is ignored.
- IDLE → START when wr_req or rd_req is high:
  - Only one request high: that requester wins.
  - Both high: the requester not served last wins. The last-served flag resets to "read", so write wins the first tie.
  - On the transition: set the gnt of the winner and pulse its seq; update the last-served flag.
- START → ACTIVE unconditionally. seq is cleared on this edge.
- ACTIVE → GAP when the granted engine's ok=1. The other engine's ok is ignored.
- On entry to GAP:
  - Clear gnt.
  - Drive the served engine's rst_n low for exactly 2 cycles.
  - Load the gap counter with GAP_CLKS-1.
- GAP → IDLE when the gap counter reaches 0.
- Requests and ok inputs are not sampled in START or GAP.

## Timing
- Reset values:
  - state=INIT, wr_gnt=rd_gnt=0, wr_seq=rd_seq=0.
  - wr_rst_n=rd_rst_n=1.
  - busy=1, err=0, last-served=read, gap counter=0, watchdog=0.
- Request seen at IDLE edge n:
  - gnt and seq are high after edge n.
  - seq is low after edge n+1, which is also when the state becomes ACTIVE.
- ok seen at ACTIVE edge m:
  - After edge m: gnt=0, CSn=1, engine rst_n=0.
  - After edge m+2: engine rst_n=1.
  - After edge m+GAP_CLKS: state is IDLE, busy=0.
- Minimum request-to-request turnaround: 2 + GAP_CLKS cycles plus the engine's transaction length.
- ok already high in the cycle after START is still accepted, so the transaction can last a single ACTIVE cycle.
- Asynchronous reset mid-transaction: returns to INIT immediately and the bus is handed back to the init engine. Engines are reset by the top-level rst_n.

## Configuration
- SD_ARB_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit watchdog clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When it reaches all-ones without ok, set err (sticky until rst_n) and take the normal GAP exit, including the engine reset.
- SD_ARB_TIMEOUT_EN undefined:
  - No watchdog logic; ACTIVE waits indefinitely.
  - err is tied to 0.

## Test plan
- Reset, init_done=0, init_csn toggling → SD_CSn follows init_csn, busy=1, no grant. Set init_done=1 → IDLE and busy=0 after one edge.
- wr_req=1 only, with a write model that raises wr_ok 600 cycles after wr_seq:
  - wr_seq high for exactly 1 cycle; wr_gnt high for 601 cycles.
  - wr_rst_n low for 2 cycles.
  - SD_CSn=1 for 8 cycles (GAP_CLKS=8), then busy=0.
- wr_req=rd_req=1 held continuously → grants alternate write, read, write, read across 4 transactions.
- rd_ok forced high while write is granted → ignored; the transaction ends only on wr_ok.
- With SD_ARB_TIMEOUT_EN, TIMEOUT_W=4, engine never asserts ok:
  - err=1 after 15 ACTIVE cycles.
  - Engine rst_n pulsed low; state returns to IDLE.
  - err remains 1 through a subsequent successful read.
- rst_n asserted during ACTIVE of a read → all outputs at reset values immediately; bus returns to the init engine.
